// File: rtl/regfile_ckpt_if.sv
// Register-file bus: two read ports, one write port, checkpoint control and status.
interface regfile_ckpt_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREG  = 32
);
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             we3;
  logic [AW-1:0]    wa3;
  logic [WIDTH-1:0] wd3;
  logic             ckpt_save;
  logic             ckpt_restore;
  logic             ckpt_valid;
  logic [NREG-1:0]  ckpt_dirty;
  logic             restore_err;

  modport master (
    output ra1, ra2, we3, wa3, wd3, ckpt_save, ckpt_restore,
    input  rd1, rd2, ckpt_valid, ckpt_dirty, restore_err
  );

  modport slave (
    input  ra1, ra2, we3, wa3, wd3, ckpt_save, ckpt_restore,
    output rd1, rd2, ckpt_valid, ckpt_dirty, restore_err
  );
endinterface

// File: rtl/regfile_ckpt.sv
// Register file with single-level shadow checkpoint and per-register dirty mask.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards a committing write to same-cycle reads.
module regfile_ckpt #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned NREG       = 32,
  parameter int unsigned ZERO_REG   = 31,
  parameter int unsigned INIT_INDEX = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  regfile_ckpt_if.slave   bus
);
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [WIDTH-1:0] main_q   [NREG];
  logic [WIDTH-1:0] main_d   [NREG];
  logic [WIDTH-1:0] shadow_q [NREG];
  logic             valid_q, valid_d;
  logic [NREG-1:0]  dirty_q, dirty_d;
  logic             err_q, err_d;

  logic wr_ok;
  logic restore_ok;
  logic wr_commit;

  function automatic logic [WIDTH-1:0] init_val(input int unsigned i);
    if (i == ZERO_REG || INIT_INDEX == 0) return '0;
    return WIDTH'(i);
  endfunction

  // Out-of-range and zero-register writes never reach storage.
  assign wr_ok      = bus.we3 && (32'(bus.wa3) < NREG) && (bus.wa3 != AW'(ZERO_REG));
  assign restore_ok = bus.ckpt_restore && valid_q;
  assign wr_commit  = wr_ok && !restore_ok;

  always_comb begin
    for (int i = 0; i < NREG; i++) main_d[i] = main_q[i];
    dirty_d = dirty_q;
    valid_d = valid_q;
    err_d   = bus.ckpt_restore && !valid_q;
    if (restore_ok) begin
      for (int i = 0; i < NREG; i++) main_d[i] = shadow_q[i];
      dirty_d = '0;
    end else begin
      if (wr_ok) begin
        main_d[bus.wa3]  = bus.wd3;
        dirty_d[bus.wa3] = 1'b1;
      end
      // Save sees the post-write image and starts a fresh dirty window.
      if (bus.ckpt_save) begin
        valid_d = 1'b1;
        dirty_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        main_q[i]   <= init_val(i);
        shadow_q[i] <= init_val(i);
      end
      valid_q <= 1'b0;
      dirty_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) main_q[i] <= main_d[i];
      if (bus.ckpt_save && !restore_ok) begin
        for (int i = 0; i < NREG; i++) shadow_q[i] <= main_d[i];
      end
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      err_q   <= err_d;
    end
  end

  function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if ((32'(a) < NREG) && (a != AW'(ZERO_REG))) begin
      v = main_q[a];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_commit && (a == bus.wa3)) v = bus.wd3;
`endif
    end
    return v;
  endfunction

  always_comb bus.rd1 = rd_port(bus.ra1);
  always_comb bus.rd2 = rd_port(bus.ra2);

  assign bus.ckpt_valid  = valid_q;
  assign bus.ckpt_dirty  = dirty_q;
  assign bus.restore_err = err_q;

`ifndef REGFILE_WRITE_BYPASS_EN
  // Commit qualifier only feeds the bypass path.
  logic unused_wr_commit;
  assign unused_wr_commit = wr_commit;
`endif
endmodule

// File: tb/tb_regfile_ckpt.sv
// Scoreboard bench for regfile_ckpt: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_ckpt;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned NREG  = 32;

  localparam int SEL_RD1   = 0;
  localparam int SEL_RD2   = 1;
  localparam int SEL_VALID = 2;
  localparam int SEL_DIRTY = 3;
  localparam int SEL_ERR   = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t q[$];
  int   n_cmp;
  int   n_bad;

  regfile_ckpt_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();

  regfile_ckpt #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_REG(31), .INIT_INDEX(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string nm, input int sel, input logic [63:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we3          = 1'b0;
    bus.ckpt_save    = 1'b0;
    bus.ckpt_restore = 1'b0;
  endtask

  // Monitor: checks every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.sel)
        SEL_RD1:   act = bus.rd1;
        SEL_RD2:   act = bus.rd2;
        SEL_VALID: act = 64'(bus.ckpt_valid);
        SEL_DIRTY: act = 64'(bus.ckpt_dirty);
        default:   act = 64'(bus.restore_err);
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    idle();
    bus.ra1 = '0;
    bus.ra2 = '0;
    bus.wa3 = '0;
    bus.wd3 = '0;
    #12 reset_n = 1'b1;

    // Reset image: register i holds i, zero register reads 0.
    for (int i = 0; i < 31; i++) begin
      tick();
      bus.ra1 = 5'(i);
      bus.ra2 = 5'(i);
      expect_val($sformatf("reset_rd1_%0d", i), SEL_RD1, 64'(i));
      expect_val($sformatf("reset_rd2_%0d", i), SEL_RD2, 64'(i));
    end
    tick();
    bus.ra1 = 5'd31;
    expect_val("reset_zero", SEL_RD1, 64'd0);
    expect_val("reset_valid", SEL_VALID, 64'd0);
    expect_val("reset_dirty", SEL_DIRTY, 64'd0);
    expect_val("reset_err", SEL_ERR, 64'd0);

    // Plain write and zero register.
    tick();
    bus.we3 = 1'b1; bus.wa3 = 5'd1; bus.wd3 = 64'd2;
    tick();
    idle();
    bus.ra1 = 5'd1; bus.ra2 = 5'd0;
    expect_val("wr_x1", SEL_RD1, 64'd2);
    expect_val("wr_x0", SEL_RD2, 64'd0);
    expect_val("wr_dirty", SEL_DIRTY, 64'h2);
    tick();
    bus.we3 = 1'b1; bus.wa3 = 5'd31; bus.wd3 = 64'd99;
    tick();
    idle();
    bus.ra1 = 5'd31;
    expect_val("zero_wr_rd", SEL_RD1, 64'd0);
    expect_val("zero_wr_dirty", SEL_DIRTY, 64'h2);

    // Checkpoint round trip; snapshot holds x1=2, others i.
    tick();
    bus.ckpt_save = 1'b1;
    tick();
    idle();
    expect_val("save_valid", SEL_VALID, 64'd1);
    expect_val("save_dirty", SEL_DIRTY, 64'd0);
    bus.we3 = 1'b1; bus.wa3 = 5'd11; bus.wd3 = 64'd45;
    tick();
    bus.wa3 = 5'd5; bus.wd3 = 64'd7;
    tick();
    idle();
    bus.ra1 = 5'd11; bus.ra2 = 5'd5;
    expect_val("post_wr_x11", SEL_RD1, 64'd45);
    expect_val("post_wr_x5", SEL_RD2, 64'd7);
    expect_val("post_wr_dirty", SEL_DIRTY, 64'h0000_0820);
    tick();
    bus.ckpt_restore = 1'b1;
    tick();
    idle();
    expect_val("rest_x11", SEL_RD1, 64'd11);
    expect_val("rest_x5", SEL_RD2, 64'd5);
    expect_val("rest_dirty", SEL_DIRTY, 64'd0);
    expect_val("rest_valid", SEL_VALID, 64'd1);
    expect_val("rest_err", SEL_ERR, 64'd0);

    // Restore beats a same-cycle write (and its bypass).
    tick();
    bus.ckpt_restore = 1'b1;
    bus.we3 = 1'b1; bus.wa3 = 5'd3; bus.wd3 = 64'd77;
    bus.ra1 = 5'd3;
    expect_val("rw_same_cycle_x3", SEL_RD1, 64'd3);
    tick();
    idle();
    expect_val("rw_after_x3", SEL_RD1, 64'd3);
    expect_val("rw_dirty", SEL_DIRTY, 64'd0);

    // Save with write captures the write in the snapshot.
    tick();
    bus.ckpt_save = 1'b1;
    bus.we3 = 1'b1; bus.wa3 = 5'd4; bus.wd3 = 64'd88;
    tick();
    bus.ckpt_save = 1'b0;
    bus.wd3 = 64'd1;
    expect_val("sw_valid", SEL_VALID, 64'd1);
    expect_val("sw_dirty", SEL_DIRTY, 64'd0);
    tick();
    idle();
    bus.ra1 = 5'd4; bus.ra2 = 5'd1;
    expect_val("sw_x4_new", SEL_RD1, 64'd1);
    expect_val("sw_dirty4", SEL_DIRTY, 64'h10);
    tick();
    bus.ckpt_restore = 1'b1;
    tick();
    idle();
    expect_val("sw_rest_x4", SEL_RD1, 64'd88);
    expect_val("sw_rest_x1", SEL_RD2, 64'd2);
    expect_val("sw_rest_dirty", SEL_DIRTY, 64'd0);

    // Asynchronous reset while a save and write are in flight.
    tick();
    bus.ckpt_save = 1'b1;
    bus.we3 = 1'b1; bus.wa3 = 5'd9; bus.wd3 = 64'd555;
    bus.ra1 = 5'd4; bus.ra2 = 5'd1;
    #2 reset_n = 1'b0;
    expect_val("arst_x4", SEL_RD1, 64'd4);
    expect_val("arst_x1", SEL_RD2, 64'd1);
    expect_val("arst_valid", SEL_VALID, 64'd0);
    expect_val("arst_dirty", SEL_DIRTY, 64'd0);
    tick();
    idle();
    #2 reset_n = 1'b1;
    tick();
    bus.ra1 = 5'd9;
    expect_val("arst_x9", SEL_RD1, 64'd9);
    expect_val("arst_valid2", SEL_VALID, 64'd0);

    // Restore without a snapshot: one-cycle error, write still commits.
    tick();
    bus.ckpt_restore = 1'b1;
    bus.we3 = 1'b1; bus.wa3 = 5'd6; bus.wd3 = 64'd66;
    expect_val("err_before", SEL_ERR, 64'd0);
    tick();
    idle();
    bus.ra1 = 5'd6; bus.ra2 = 5'd2;
    expect_val("err_pulse", SEL_ERR, 64'd1);
    expect_val("err_x6", SEL_RD1, 64'd66);
    expect_val("err_x2", SEL_RD2, 64'd2);
    expect_val("err_valid", SEL_VALID, 64'd0);
    expect_val("err_dirty", SEL_DIRTY, 64'h40);
    tick();
    expect_val("err_clear", SEL_ERR, 64'd0);

    // Same-cycle write/read of x7.
    tick();
    bus.we3 = 1'b1; bus.wa3 = 5'd7; bus.wd3 = 64'd123;
    bus.ra1 = 5'd7;
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_val("bypass_x7", SEL_RD1, 64'd123);
`else
    expect_val("bypass_x7", SEL_RD1, 64'd7);
`endif
    tick();
    idle();
    expect_val("after_x7", SEL_RD1, 64'd123);

    tick();
    tick();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_ckpt.md
Name: regfile_ckpt

Overview:
Parametrised successor to the core register file: WIDTH-bit by NREG-entry storage with two asynchronous read ports and one synchronous write port, plus a single-level shadow checkpoint bank.
- On an exception, the exception unit restores the architectural state to the last saved checkpoint.
- Sits in the decode/writeback stage of the datapath.
- A per-register dirty mask tells the exception unit which registers changed since the last save.

Parameters:
WIDTH, 64, data width of each register
NREG, 32, number of registers; address width AW = $clog2(NREG)
ZERO_REG, 31, index of the hardwired-zero register
INIT_INDEX, 1, 1 = reset loads register i with value i; 0 = reset loads all registers with 0

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
rd1  out  WIDTH  read data, port 1 (combinational)
rd2  out  WIDTH  read data, port 2 (combinational)
we3  in  1  write enable
wa3  in  AW  write address
wd3  in  WIDTH  write data
ckpt_save  in  1  copy main bank into shadow bank
ckpt_restore  in  1  copy shadow bank into main bank
ckpt_valid  out  1  shadow bank holds a saved snapshot
ckpt_dirty  out  NREG  bit i = register i written since last save/restore
restore_err  out  1  one-cycle pulse: restore requested with ckpt_valid=0

Behaviour:
Reset:
- reset_n low forces all of the following immediately, independent of clk, and overrides any operation in flight.
- Main and shadow register i load (INIT_INDEX ? i : 0). ZERO_REG storage loads 0.
- ckpt_valid=0, ckpt_dirty=0, restore_err=0.

Reads:
- rd1 and rd2 are combinational from ra1 and ra2, with zero added latency.
- A read of ZERO_REG always returns 0.
- Both ports may address the same register.

Writes:
- When we3=1, reg[wa3] <= wd3 on the rising edge. The new value is visible on the read ports after that edge.
- A write to ZERO_REG is ignored and does not set dirty.
- Any other committed write sets ckpt_dirty[wa3].

Save (ckpt_save=1, ckpt_restore=0):
- On the edge, shadow[i] <= next main value for every i, so a same-cycle write is included in the snapshot.
- ckpt_valid <= 1. ckpt_dirty <= 0.

Restore (ckpt_restore=1 and ckpt_valid=1):
- On the edge, main[i] <= shadow[i] for every i. ckpt_dirty <= 0.
- ckpt_valid stays 1, so repeated restores return to the same snapshot.

Restore with ckpt_valid=0:
- Main bank is unchanged; a same-cycle write still commits normally.
- restore_err=1 for exactly one cycle, then returns to 0.

Priority within one cycle: restore > save > write.
- A valid restore drops a same-cycle write (no dirty update).
- A valid restore also drops a same-cycle save.
- Save with write: the write commits and is captured in the snapshot; dirty is cleared.

Out-of-range addresses (NREG not a power of 2):
- Reads return 0.
- Writes are ignored.

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN

Defined:
- When we3=1, wa3==raN, wa3!=ZERO_REG, and the write will commit this cycle (no valid restore), rdN returns wd3 combinationally in the same cycle.
- Gives write-before-read semantics for a same-cycle writeback/decode pair.

Undefined:
- rdN returns the stored (old) value until after the edge.

Test Plan:
Reset (INIT_INDEX=1):
- Pulse reset_n low mid-cycle, then sweep ra1=ra2 over 0..30 -> rd1=rd2=i. ra1=31 -> 0. ckpt_valid=0, ckpt_dirty=0.
Write / zero register:
- Write wa3=1, wd3=2, then read ra1=1, ra2=0 -> rd1=2, rd2=0.
- Write wa3=31, wd3=99 -> rd(31)=0 and ckpt_dirty[31]=0.
Checkpoint round-trip:
- ckpt_save, then write x11=45 and x5=7 -> ckpt_dirty has bits 11 and 5 set.
- Then ckpt_restore -> rd(11)=11, rd(5)=5, ckpt_dirty=0, ckpt_valid=1.
Priorities:
- Same cycle ckpt_restore with a write of x3=77 -> rd(3) equals the snapshot value, dirty[3]=0.
- Same cycle ckpt_save with a write of x4=88, then write x4=1, then restore -> rd(4)=88.
Restore error:
- ckpt_restore with ckpt_valid=0 -> restore_err high for exactly one cycle, registers unchanged.
Bypass:
- we3=1, wa3=ra1=7, wd3=123, read before the edge -> rd1=123 with the macro defined, rd1=7 without it.
Reset mid-operation:
- Assert reset_n low while ckpt_save and we3 are high -> all registers return to i, ckpt_valid=0.
